// File: rtl/lookup_reverse_if.sv
// Request/result and table-write bus for the lookup_reverse value->key search engine.
interface lookup_reverse_if #(
    parameter int KEY_W = 4,
    parameter int VAL_W = 8
);
    logic             WrEn;
    logic [KEY_W-1:0] WrKey;
    logic [VAL_W-1:0] WrVal;
    logic             Req;
    logic [VAL_W-1:0] ReqVal;
    logic             Busy;
    logic             Done;
    logic             Hit;
    logic [KEY_W-1:0] KeyOut;

    modport master (
        output WrEn, WrKey, WrVal, Req, ReqVal,
        input  Busy, Done, Hit, KeyOut
    );

    modport slave (
        input  WrEn, WrKey, WrVal, Req, ReqVal,
        output Busy, Done, Hit, KeyOut
    );
endinterface

// File: rtl/lookup_reverse.sv
// Reverse search over a writable 16x8 table: scans keys 0..DEPTH-1 one per cycle and
// reports the lowest key whose entry equals the requested value, or a miss.
module lookup_reverse #(
    parameter int KEY_W = 4,
    parameter int VAL_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    lookup_reverse_if.slave  bus
);
    localparam int DEPTH = 2 ** KEY_W;
    localparam logic [KEY_W-1:0] LAST_KEY = KEY_W'(DEPTH - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t           state_r, state_s;
    logic [KEY_W-1:0] idx_r, idx_s;
    logic [VAL_W-1:0] target_r, target_s;
    logic [VAL_W-1:0] table_r [DEPTH];
    logic             busy_r;
    logic             done_r, done_s;
    logic             hit_r, hit_s;
    logic [KEY_W-1:0] key_r, key_s;

    function automatic logic [VAL_W-1:0] default_entry(input logic [KEY_W-1:0] k);
        case (k)
            KEY_W'(0): default_entry = VAL_W'(8'h01);
            KEY_W'(1): default_entry = VAL_W'(8'h03);
            KEY_W'(2): default_entry = VAL_W'(8'h05);
            KEY_W'(3): default_entry = VAL_W'(8'h07);
            default:   default_entry = VAL_W'(8'hFF);
        endcase
    endfunction

    // Table storage: restored to defaults on reset, writable in any state
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                table_r[k] <= default_entry(KEY_W'(k));
            end
        end else if (bus.WrEn) begin
            table_r[bus.WrKey] <= bus.WrVal;
        end
    end

    // State and result registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r  <= IDLE;
            idx_r    <= '0;
            target_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hit_r    <= 1'b0;
            key_r    <= '0;
        end else begin
            state_r  <= state_s;
            idx_r    <= idx_s;
            target_r <= target_s;
            busy_r   <= (state_s == SCAN);
            done_r   <= done_s;
            hit_r    <= hit_s;
            key_r    <= key_s;
        end
    end

    // Next-state and result logic; the compare uses pre-edge table contents
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        target_s = target_r;
        done_s   = 1'b0;
        hit_s    = hit_r;
        key_s    = key_r;
        case (state_r)
            IDLE: begin
                if (bus.Req) begin
                    target_s = bus.ReqVal;
                    idx_s    = '0;
                    state_s  = SCAN;
                end else begin
                    state_s  = IDLE;
                end
            end
            SCAN: begin
                if (table_r[idx_r] == target_r) begin
                    hit_s   = 1'b1;
                    key_s   = idx_r;
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else if (idx_r == LAST_KEY) begin
                    hit_s   = 1'b0;
                    key_s   = '0;
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    idx_s   = idx_r + KEY_W'(1'b1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign bus.Busy   = busy_r;
    assign bus.Done   = done_r;
    assign bus.Hit    = hit_r;
    assign bus.KeyOut = key_r;
endmodule

// File: tb/tb_lookup_reverse.sv
// Directed bench for lookup_reverse: expected results are queued when a search is issued
// and compared when Done is observed.
module tb_lookup_reverse;
    logic Clk = 1'b0;
    logic Reset;
    int   passed = 0;
    int   total  = 0;

    typedef struct {
        logic       hit;
        logic [3:0] key;
        int         lat;
    } exp_t;
    exp_t sbq[$];

    lookup_reverse_if #(.KEY_W(4), .VAL_W(8)) bus ();

    lookup_reverse #(.KEY_W(4), .VAL_W(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic write_entry(input logic [3:0] k, input logic [7:0] v);
        @(negedge Clk);
        bus.WrEn = 1'b1; bus.WrKey = k; bus.WrVal = v;
        @(negedge Clk);
        bus.WrEn = 1'b0;
    endtask

    // wr_at: -1 = write alongside Req, n>=0 = write driven after edge n, -99 = none.
    // req_at: extra Req pulse (value 0x01) driven after edge n while busy, -99 = none.
    task automatic search(input string tag, input logic [7:0] val, input logic exp_hit,
                          input logic [3:0] exp_key, input int exp_lat, input int wr_at,
                          input logic [3:0] wk, input logic [7:0] wv, input int req_at);
        int   n;
        exp_t e;
        sbq.push_back('{hit: exp_hit, key: exp_key, lat: exp_lat});
        @(negedge Clk);
        bus.Req = 1'b1; bus.ReqVal = val;
        if (wr_at == -1) begin
            bus.WrEn = 1'b1; bus.WrKey = wk; bus.WrVal = wv;
        end
        @(negedge Clk);
        n = 0;
        bus.Req = 1'b0; bus.WrEn = 1'b0;
        if (wr_at == 0) begin
            bus.WrEn = 1'b1; bus.WrKey = wk; bus.WrVal = wv;
        end
        chk({tag, "_busy_start"}, 32'(bus.Busy), 32'd1);
        while (n < 40) begin
            @(negedge Clk);
            n++;
            bus.WrEn = 1'b0; bus.Req = 1'b0;
            if (bus.Done) break;
            if (n == wr_at) begin
                bus.WrEn = 1'b1; bus.WrKey = wk; bus.WrVal = wv;
            end
            if (n == req_at) begin
                bus.Req = 1'b1; bus.ReqVal = 8'h01;
            end
            if (!bus.Busy) chk({tag, "_busy_during"}, 32'(bus.Busy), 32'd1);
        end
        e = sbq.pop_front();
        chk({tag, "_done_seen"}, 32'(bus.Done), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'(e.lat));
        chk({tag, "_hit"}, 32'(bus.Hit), 32'(e.hit));
        chk({tag, "_key"}, 32'(bus.KeyOut), 32'(e.key));
        chk({tag, "_busy_end"}, 32'(bus.Busy), 32'd0);
        @(negedge Clk);
        chk({tag, "_done_pulse"}, 32'(bus.Done), 32'd0);
        chk({tag, "_hold"}, {27'd0, bus.Hit, bus.KeyOut}, {27'd0, e.hit, e.key});
    endtask

    initial begin
        int done_cnt;
        Reset = 1'b1;
        bus.WrEn = 1'b0; bus.WrKey = 4'd0; bus.WrVal = 8'h00;
        bus.Req = 1'b0;  bus.ReqVal = 8'h00;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_done", 32'(bus.Done), 32'd0);
        chk("rst_hit", 32'(bus.Hit), 32'd0);
        chk("rst_key", 32'(bus.KeyOut), 32'd0);

        search("v05", 8'h05, 1'b1, 4'd2, 3, -99, 4'd0, 8'h00, -99);
        search("vff_dup", 8'hFF, 1'b1, 4'd4, 5, -99, 4'd0, 8'h00, -99);
        search("v42_miss", 8'h42, 1'b0, 4'd0, 16, -99, 4'd0, 8'h00, -99);

        write_entry(4'd9, 8'h42);
        search("k9_hit", 8'h42, 1'b1, 4'd9, 10, -99, 4'd0, 8'h00, -99);
        write_entry(4'd9, 8'h00);
        search("k9_cleared", 8'h42, 1'b0, 4'd0, 16, -99, 4'd0, 8'h00, -99);

        search("wr_ahead", 8'h99, 1'b1, 4'd3, 4, 1, 4'd3, 8'h99, -99);
        write_entry(4'd3, 8'h07);
        search("wr_behind", 8'h99, 1'b0, 4'd0, 16, 1, 4'd0, 8'h99, -99);
        write_entry(4'd0, 8'h01);
        search("wr_current", 8'h99, 1'b0, 4'd0, 16, 1, 4'd1, 8'h99, -99);
        write_entry(4'd1, 8'h03);
        search("wr_with_req", 8'h77, 1'b1, 4'd7, 8, -1, 4'd7, 8'h77, -99);
        write_entry(4'd7, 8'hFF);
        search("req_ignored", 8'h42, 1'b0, 4'd0, 16, -99, 4'd0, 8'h00, 3);
        search("v01_key0", 8'h01, 1'b1, 4'd0, 1, -99, 4'd0, 8'h00, -99);

        // Reset mid-scan after planting a value that the restored table must not hold
        write_entry(4'd5, 8'h42);
        @(negedge Clk);
        bus.Req = 1'b1; bus.ReqVal = 8'h42;
        @(negedge Clk);
        bus.Req = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("midrst_busy", 32'(bus.Busy), 32'd0);
        chk("midrst_done", 32'(bus.Done), 32'd0);
        chk("midrst_hit", 32'(bus.Hit), 32'd0);
        chk("midrst_key", 32'(bus.KeyOut), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (bus.Done) done_cnt++;
        end
        chk("midrst_no_done", 32'(done_cnt), 32'd0);
        search("post_rst_table", 8'h42, 1'b0, 4'd0, 16, -99, 4'd0, 8'h00, -99);
        search("post_rst_v05", 8'h05, 1'b1, 4'd2, 3, -99, 4'd0, 8'h00, -99);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
